ov_dvp_capture: RTL and testbench



---
 rtl/ov_capture_pkg.sv | 36 +++
 rtl/ov_dvp_capture_if.sv | 27 ++
 rtl/ov_capture_fifo.sv | 63 ++++++
 rtl/ov_dvp_capture.sv | 215 +++++++++++++++++++++
 tb/tb_ov_dvp_capture.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov_capture_pkg.sv
// Shared types and helpers for the OV7670/OV9655 DVP capture block:
// pixel-format codes, FSM states, FIFO entry layout and the byte-pair decoder.
package ov_capture_pkg;

    localparam logic [31:0] PIXEL_FORMAT_RGB444 = 32'd0;
    localparam logic [31:0] PIXEL_FORMAT_RGB565 = 32'd1;
    localparam logic [31:0] PIXEL_FORMAT_RGB555 = 32'd2;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_END,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [23:0] data;
    } fifo_entry_t;

    // Unknown format codes fall back to RGB565.
    function automatic logic [23:0] decode_pixel(input logic [31:0] fmt,
                                                 input logic [7:0]  b0,
                                                 input logic [7:0]  b1);
        logic [23:0] px;
        if (fmt == PIXEL_FORMAT_RGB444) begin
            px = {b0[3:0], 4'h0, b1[7:4], 4'h0, b1[3:0], 4'h0};
        end else if (fmt == PIXEL_FORMAT_RGB555) begin
            px = {b0[6:2], 3'b000, b0[1:0], b1[7:5], 3'b000, b1[4:0], 3'b000};
        end else begin
            px = {b0[7:3], 3'b000, b0[2:0], b1[7:5], 2'b00, b1[4:0], 3'b000};
        end
        return px;
    endfunction

endpackage

// File: rtl/ov_dvp_capture_if.sv
// AXI4-Stream-style pixel port carrying RGB888 pixels with frame-start (TUSER)
// and end-of-line (TLAST) markers.
interface ov_dvp_capture_if;

    logic [23:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        M_TUSER;
    logic        M_TLAST;

    modport master (
        output M_TDATA,
        output M_TVALID,
        output M_TUSER,
        output M_TLAST,
        input  M_TREADY
    );

    modport slave (
        input  M_TDATA,
        input  M_TVALID,
        input  M_TUSER,
        input  M_TLAST,
        output M_TREADY
    );

endinterface

// File: rtl/ov_capture_fifo.sv
// Synchronous FIFO of pixel entries with a registered read stage; the output
// register counts toward capacity, so exactly DEPTH entries can be held.
module ov_capture_fifo
    import ov_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  fifo_entry_t i_wdata,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output fifo_entry_t o_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    fifo_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    fifo_entry_t   r_rdata;
    logic          r_valid;
    logic          w_load;

    // Refill the output register whenever it is empty or being consumed.
    assign w_load  = (r_count != '0) && (!r_valid || i_pop);
    assign o_full  = (r_count + (AW + 1)'(r_valid)) == DEPTH_W;
    assign o_empty = !r_valid;
    assign o_rdata = r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr  <= r_rptr + 1'b1;
                r_rdata <= r_mem[r_rptr];
                r_valid <= 1'b1;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
            r_count <= r_count + (AW + 1)'(i_push) - (AW + 1)'(w_load);
        end
    end

endmodule

// File: rtl/ov_dvp_capture.sv
// DVP camera receiver: pairs sensor bytes into RGB888 pixels and streams them out.
// Define OV_CAPTURE_STATS_EN to add FRAME_CNT / LAST_LINE_PIXELS / LAST_FRAME_LINES.
module ov_dvp_capture
    import ov_capture_pkg::*;
#(
    parameter int unsigned HSIZE      = 640,
    parameter int unsigned VSIZE      = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                    PCLK,
    input  logic                    RESET,
    input  logic                    VSYNC,
    input  logic                    HREF,
    input  logic [7:0]              DATA,
    input  logic [31:0]             PIXEL_FORMAT,
    ov_dvp_capture_if.master        m_axis,
    output logic                    OVERFLOW,
    output logic                    LINE_ERR
`ifdef OV_CAPTURE_STATS_EN
    ,
    output logic [15:0]             FRAME_CNT,
    output logic [15:0]             LAST_LINE_PIXELS,
    output logic [15:0]             LAST_FRAME_LINES
`endif
);

    localparam logic [15:0] HSIZE_W = 16'(HSIZE);
    localparam logic [15:0] VSIZE_W = 16'(VSIZE);

    logic        r_vsync;
    logic        r_vsync_d;
    logic        r_href;
    logic        r_href_d;
    logic [7:0]  r_data;

    state_t      r_state;
    logic [31:0] r_fmt;
    logic        r_phase;
    logic [7:0]  r_byte0;
    logic [15:0] r_pix_cnt;
    logic [15:0] r_line_cnt;
    logic        r_tuser_arm;
    logic        r_pix_vld;
    logic [23:0] r_pix_data;
    logic        r_pix_last;
    logic        r_overflow;
    logic        r_line_err;

    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_href_rise;
    logic        w_href_fall;
    logic        w_active;
    logic        w_phase;
    logic        w_line_end;
    logic [15:0] w_line_num;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    fifo_entry_t w_entry;
    fifo_entry_t w_rdata;

    assign w_vs_rise   = r_vsync && !r_vsync_d;
    assign w_vs_fall   = !r_vsync && r_vsync_d;
    assign w_href_rise = r_href && !r_href_d;
    assign w_href_fall = !r_href && r_href_d;
    assign w_active    = (r_state == ACTIVE);
    assign w_phase     = w_href_rise ? 1'b0 : r_phase;
    assign w_line_end  = w_active && w_href_fall;
    assign w_line_num  = r_line_cnt + 16'd1;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop   = !w_empty && m_axis.M_TREADY;
    assign w_drop  = r_pix_vld && w_full && !w_pop;
    assign w_push  = r_pix_vld && !w_drop;
    assign w_entry = {r_tuser_arm, r_pix_last, r_pix_data};

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= '0;
        end else begin
            r_vsync   <= VSYNC;
            r_vsync_d <= r_vsync;
            r_href    <= HREF;
            r_href_d  <= r_href;
            r_data    <= DATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_state     <= WAIT_VS;
            r_fmt       <= PIXEL_FORMAT_RGB565;
            r_phase     <= 1'b0;
            r_byte0     <= '0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_tuser_arm <= 1'b0;
            r_pix_vld   <= 1'b0;
            r_pix_data  <= '0;
            r_pix_last  <= 1'b0;
            r_overflow  <= 1'b0;
            r_line_err  <= 1'b0;
        end else begin
            r_pix_vld  <= 1'b0;
            r_line_err <= 1'b0;
            if (w_push) begin
                r_tuser_arm <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            unique case (r_state)
                WAIT_VS: begin
                    if (r_vsync) begin
                        r_state <= WAIT_END;
                    end
                end
                WAIT_END: begin
                    if (r_vsync) begin
                        r_fmt <= PIXEL_FORMAT;
                    end
                    if (w_vs_fall) begin
                        r_state     <= ACTIVE;
                        r_line_cnt  <= '0;
                        r_tuser_arm <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_vs_rise) begin
                        r_state <= WAIT_END;
                    end
                end
                default: r_state <= WAIT_VS;
            endcase

            if (w_active && r_href) begin
                r_phase <= !w_phase;
                if (!w_phase) begin
                    r_byte0 <= r_data;
                    if (w_href_rise) begin
                        r_pix_cnt <= '0;
                    end
                end else begin
                    r_pix_cnt <= r_pix_cnt + 16'd1;
                    // Pixels beyond the line length are counted but never pushed.
                    if (r_pix_cnt < HSIZE_W) begin
                        r_pix_vld  <= 1'b1;
                        r_pix_data <= decode_pixel(r_fmt, r_byte0, r_data);
                        r_pix_last <= (r_pix_cnt == HSIZE_W - 16'd1);
                    end
                end
            end

            if (w_line_end) begin
                r_line_cnt <= w_line_num;
                r_line_err <= (r_pix_cnt != HSIZE_W) || r_phase || (w_line_num > VSIZE_W);
            end
        end
    end

    ov_capture_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst   (RESET),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_rdata)
    );

    assign m_axis.M_TVALID = !w_empty;
    assign m_axis.M_TDATA  = w_rdata.data;
    assign m_axis.M_TUSER  = w_rdata.tuser;
    assign m_axis.M_TLAST  = w_rdata.tlast;
    assign OVERFLOW        = r_overflow;
    assign LINE_ERR        = r_line_err;

`ifdef OV_CAPTURE_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_last_line_pixels;
    logic [15:0] r_last_frame_lines;

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_frame_cnt        <= '0;
            r_last_line_pixels <= '0;
            r_last_frame_lines <= '0;
        end else begin
            if (w_active && w_vs_rise) begin
                r_frame_cnt        <= r_frame_cnt + 16'd1;
                r_last_frame_lines <= r_line_cnt;
            end
            if (w_line_end) begin
                r_last_line_pixels <= r_pix_cnt;
            end
        end
    end

    assign FRAME_CNT        = r_frame_cnt;
    assign LAST_LINE_PIXELS = r_last_line_pixels;
    assign LAST_FRAME_LINES = r_last_frame_lines;
`endif

endmodule

// File: tb/tb_ov_dvp_capture.sv
// Directed bench for ov_dvp_capture: unit A (HSIZE=4, VSIZE=2, depth 4) and
// unit B (HSIZE=8, VSIZE=2, depth 4) share the camera pins.
module tb_ov_dvp_capture;
    import ov_capture_pkg::*;

    logic        PCLK = 1'b0;
    logic        RESET;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  DATA;
    logic [31:0] PIXEL_FORMAT;
    logic        ovf_a;
    logic        lerr_a;
    logic        ovf_b;
    logic        lerr_b;
`ifdef OV_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_a;
    logic [15:0] line_pix_a;
    logic [15:0] frame_lines_a;
    logic [15:0] frame_cnt_b;
    logic [15:0] line_pix_b;
    logic [15:0] frame_lines_b;
`endif

    ov_dvp_capture_if axis_a ();
    ov_dvp_capture_if axis_b ();

    always #5 PCLK = ~PCLK;

    ov_dvp_capture #(
        .HSIZE      (4),
        .VSIZE      (2),
        .FIFO_DEPTH (4)
    ) u_dut_a (
        .PCLK             (PCLK),
        .RESET            (RESET),
        .VSYNC            (VSYNC),
        .HREF             (HREF),
        .DATA             (DATA),
        .PIXEL_FORMAT     (PIXEL_FORMAT),
        .m_axis           (axis_a),
        .OVERFLOW         (ovf_a),
        .LINE_ERR         (lerr_a)
`ifdef OV_CAPTURE_STATS_EN
        ,
        .FRAME_CNT        (frame_cnt_a),
        .LAST_LINE_PIXELS (line_pix_a),
        .LAST_FRAME_LINES (frame_lines_a)
`endif
    );

    ov_dvp_capture #(
        .HSIZE      (8),
        .VSIZE      (2),
        .FIFO_DEPTH (4)
    ) u_dut_b (
        .PCLK             (PCLK),
        .RESET            (RESET),
        .VSYNC            (VSYNC),
        .HREF             (HREF),
        .DATA             (DATA),
        .PIXEL_FORMAT     (PIXEL_FORMAT),
        .m_axis           (axis_b),
        .OVERFLOW         (ovf_b),
        .LINE_ERR         (lerr_b)
`ifdef OV_CAPTURE_STATS_EN
        ,
        .FRAME_CNT        (frame_cnt_b),
        .LAST_LINE_PIXELS (line_pix_b),
        .LAST_FRAME_LINES (frame_lines_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int lerr_a_cnt = 0;

    logic [23:0] cap_a_data [$];
    logic        cap_a_user [$];
    logic        cap_a_last [$];
    logic [23:0] cap_b_data [$];
    logic [7:0]  line_q [$];

    // Records each accepted beat just before the edge that transfers it.
    always @(negedge PCLK) begin
        #2;
        if (axis_a.M_TVALID && axis_a.M_TREADY) begin
            cap_a_data.push_back(axis_a.M_TDATA);
            cap_a_user.push_back(axis_a.M_TUSER);
            cap_a_last.push_back(axis_a.M_TLAST);
        end
        if (axis_b.M_TVALID && axis_b.M_TREADY) begin
            cap_b_data.push_back(axis_b.M_TDATA);
        end
        if (lerr_a) begin
            lerr_a_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic vsync_pulse();
        step();
        VSYNC = 1'b1;
        idle(3);
        step();
        VSYNC = 1'b0;
        idle(3);
    endtask

    task automatic send_line();
        foreach (line_q[i]) begin
            step();
            HREF = 1'b1;
            DATA = line_q[i];
        end
        step();
        HREF = 1'b0;
        DATA = 8'h00;
        idle(4);
    endtask

    task automatic clear_caps();
        cap_a_data.delete();
        cap_a_user.delete();
        cap_a_last.delete();
        cap_b_data.delete();
        lerr_a_cnt = 0;
    endtask

    function automatic logic [31:0] get_a_data(input int i);
        return (i < cap_a_data.size()) ? 32'(cap_a_data[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_a_user(input int i);
        return (i < cap_a_user.size()) ? 32'(cap_a_user[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_a_last(input int i);
        return (i < cap_a_last.size()) ? 32'(cap_a_last[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_b_data(input int i);
        return (i < cap_b_data.size()) ? 32'(cap_b_data[i]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        RESET          = 1'b1;
        VSYNC          = 1'b0;
        HREF           = 1'b0;
        DATA           = 8'h00;
        PIXEL_FORMAT   = PIXEL_FORMAT_RGB565;
        axis_a.M_TREADY = 1'b1;
        axis_b.M_TREADY = 1'b1;

        // Reset state
        idle(3);
        #2;
        check_eq("rst_tvalid", 32'(axis_a.M_TVALID), 32'd0);
        check_eq("rst_tdata", 32'(axis_a.M_TDATA), 32'd0);
        check_eq("rst_tuser", 32'(axis_a.M_TUSER), 32'd0);
        check_eq("rst_tlast", 32'(axis_a.M_TLAST), 32'd0);
        check_eq("rst_overflow", 32'(ovf_a), 32'd0);
        check_eq("rst_line_err", 32'(lerr_a), 32'd0);
        step();
        RESET = 1'b0;

        // RGB565 frame, two 4-pixel lines
        PIXEL_FORMAT = PIXEL_FORMAT_RGB565;
        vsync_pulse();
        clear_caps();
        line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'hF8, 8'h1F, 8'h07, 8'hE0};
        send_line();
        send_line();
        idle(10);
        check_eq("f565_count", 32'(cap_a_data.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("f565_data%0d", i), get_a_data(i),
                     (i % 2 == 0) ? 32'hF800F8 : 32'h00FC00);
            check_eq($sformatf("f565_user%0d", i), get_a_user(i), (i == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("f565_last%0d", i), get_a_last(i), (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        check_eq("f565_line_err", 32'(lerr_a_cnt), 32'd0);
        check_eq("f565_overflow", 32'(ovf_a), 32'd0);

        // RGB444 pixel and input-to-output latency
        PIXEL_FORMAT = PIXEL_FORMAT_RGB444;
        vsync_pulse();
        clear_caps();
        step();
        HREF = 1'b1;
        DATA = 8'h0A;
        step();
        DATA = 8'h5C;
        step();
        HREF = 1'b0;
        DATA = 8'h00;
        #2;
        check_eq("lat_k1_tvalid", 32'(axis_a.M_TVALID), 32'd0);
        step();
        #2;
        check_eq("lat_k2_tvalid", 32'(axis_a.M_TVALID), 32'd0);
        step();
        #2;
        check_eq("lat_k3_tvalid", 32'(axis_a.M_TVALID), 32'd0);
        step();
        #2;
        check_eq("lat_k4_tvalid", 32'(axis_a.M_TVALID), 32'd1);
        check_eq("rgb444_data", 32'(axis_a.M_TDATA), 32'hA050C0);
        check_eq("rgb444_user", 32'(axis_a.M_TUSER), 32'd1);
        idle(4);

        // RGB555 pixel
        PIXEL_FORMAT = PIXEL_FORMAT_RGB555;
        vsync_pulse();
        clear_caps();
        line_q = '{8'h7C, 8'h00};
        send_line();
        idle(4);
        check_eq("rgb555_count", 32'(cap_a_data.size()), 32'd1);
        check_eq("rgb555_data", get_a_data(0), 32'hF80000);

        // Reset in the middle of a line with pixels buffered
        PIXEL_FORMAT = PIXEL_FORMAT_RGB565;
        vsync_pulse();
        axis_a.M_TREADY = 1'b0;
        clear_caps();
        line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (line_q[i]) begin
            step();
            HREF = 1'b1;
            DATA = line_q[i];
        end
        idle(4);
        #2;
        check_eq("midrst_pre_tvalid", 32'(axis_a.M_TVALID), 32'd1);
        check_eq("midrst_pre_tdata", 32'(axis_a.M_TDATA), 32'hF800F8);
        step();
        RESET = 1'b1;
        step();
        #2;
        check_eq("midrst_tvalid", 32'(axis_a.M_TVALID), 32'd0);
        check_eq("midrst_tdata", 32'(axis_a.M_TDATA), 32'd0);
        step();
        RESET = 1'b0;
        HREF  = 1'b0;
        axis_a.M_TREADY = 1'b1;
        line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'hF8, 8'h1F, 8'h07, 8'hE0};
        send_line();
        idle(6);
        check_eq("midrst_no_output", 32'(cap_a_data.size()), 32'd0);
        vsync_pulse();
        send_line();
        idle(8);
        check_eq("midrst_resume_count", 32'(cap_a_data.size()), 32'd4);
        check_eq("midrst_resume_user", get_a_user(0), 32'd1);
        check_eq("midrst_resume_data", get_a_data(0), 32'hF800F8);

        // Odd-length line
        vsync_pulse();
        clear_caps();
        line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'hF8};
        send_line();
        idle(6);
        check_eq("odd_count", 32'(cap_a_data.size()), 32'd2);
        check_eq("odd_last0", get_a_last(0), 32'd0);
        check_eq("odd_last1", get_a_last(1), 32'd0);
        check_eq("odd_line_err_pulses", 32'(lerr_a_cnt), 32'd1);

        // Backpressure overflow on unit B (HSIZE=8, depth 4)
        check_eq("ovf_b_before", 32'(ovf_b), 32'd0);
        vsync_pulse();
        axis_b.M_TREADY = 1'b0;
        clear_caps();
        line_q = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04,
                   8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08};
        send_line();
        idle(2);
        #2;
        check_eq("ovf_b_flag", 32'(ovf_b), 32'd1);
        check_eq("ovf_b_user", 32'(axis_b.M_TUSER), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            check_eq($sformatf("hold%0d_tvalid", i), 32'(axis_b.M_TVALID), 32'd1);
            check_eq($sformatf("hold%0d_tdata", i), 32'(axis_b.M_TDATA), 32'h000008);
        end
        step();
        axis_b.M_TREADY = 1'b1;
        idle(10);
        check_eq("drain_count", 32'(cap_b_data.size()), 32'd4);
        check_eq("drain_data0", get_b_data(0), 32'h000008);
        check_eq("drain_data1", get_b_data(1), 32'h000010);
        check_eq("drain_data2", get_b_data(2), 32'h000018);
        check_eq("drain_data3", get_b_data(3), 32'h000020);
        check_eq("ovf_b_sticky", 32'(ovf_b), 32'd1);

`ifdef OV_CAPTURE_STATS_EN
        // Three complete frames of two 4-pixel lines
        step();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        PIXEL_FORMAT = PIXEL_FORMAT_RGB565;
        line_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'hF8, 8'h1F, 8'h07, 8'hE0};
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            send_line();
            send_line();
        end
        vsync_pulse();
        idle(2);
        #2;
        check_eq("stats_frame_cnt", 32'(frame_cnt_a), 32'd3);
        check_eq("stats_line_pixels", 32'(line_pix_a), 32'd4);
        check_eq("stats_frame_lines", 32'(frame_lines_a), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
